// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between N requesters and the arbiter
interface rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  modport master (output req, input gnt, gnt_valid, gnt_id);
  modport slave  (input req, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way fixed-priority / round-robin arbiter with optional grant hold
module rr_arbiter #(
  parameter int N    = 4,
  parameter int MODE = 1,
  parameter int HOLD = 1,
  parameter int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input logic         clock,
  input logic         reset,
  rr_arbiter_if.slave io_arb
);
  logic [N-1:0]   r_gnt;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_k;
  logic [IDW-1:0] w_nptr;
  logic [N-1:0]   w_t;
  logic           w_any;
  logic           w_hold;
  int             w_idx;
  assign w_any  = |io_arb.req;
  assign w_hold = (HOLD != 0) && r_valid && |(io_arb.req & r_gnt);
  assign w_nptr = (w_k == IDW'(N - 1)) ? '0 : w_k + 1'b1;
  // scan from the far end so the first hit in priority order is the one left in w_k
  always_comb begin
    w_k   = '0;
    w_idx = 0;
    w_t   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      w_idx = (MODE != 0) ? (int'(r_ptr) + j) % N : j;
      w_t   = io_arb.req >> w_idx;
      if (w_t[0]) w_k = IDW'(w_idx);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (!w_hold) begin
      if (!w_any) begin
        r_gnt   <= '0;
        r_valid <= 1'b0;
        r_id    <= '0;
      end else begin
        r_gnt   <= N'(1) << w_k;
        r_valid <= 1'b1;
        r_id    <= w_k;
        if (MODE != 0) r_ptr <= w_nptr;
      end
    end
  end
  assign io_arb.gnt       = r_gnt;
  assign io_arb.gnt_valid = r_valid;
  assign io_arb.gnt_id    = r_id;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench running five arbiter configurations on shared stimulus
module tb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  always #5 clk = ~clk;

  rr_arbiter_if #(.N(4)) a0 ();
  rr_arbiter_if #(.N(4)) a1 ();
  rr_arbiter_if #(.N(4)) a2 ();
  rr_arbiter_if #(.N(4)) a3 ();
  rr_arbiter_if #(.N(1)) a4 ();
  assign a0.req = req;
  assign a1.req = req;
  assign a2.req = req;
  assign a3.req = req;
  assign a4.req = req[0];

  rr_arbiter #(.N(4), .MODE(1), .HOLD(1)) u0 (.clock(clk), .reset(rst), .io_arb(a0));
  rr_arbiter #(.N(4), .MODE(1), .HOLD(0)) u1 (.clock(clk), .reset(rst), .io_arb(a1));
  rr_arbiter #(.N(4), .MODE(0), .HOLD(0)) u2 (.clock(clk), .reset(rst), .io_arb(a2));
  rr_arbiter #(.N(4), .MODE(0), .HOLD(1)) u3 (.clock(clk), .reset(rst), .io_arb(a3));
  rr_arbiter #(.N(1), .MODE(1), .HOLD(1)) u4 (.clock(clk), .reset(rst), .io_arb(a4));

  logic [4:0][3:0] ag;
  logic [4:0][1:0] ai;
  logic [4:0]      av;
  assign ag = {{3'b0, a4.gnt}, a3.gnt, a2.gnt, a1.gnt, a0.gnt};
  assign ai = {{1'b0, a4.gnt_id}, a3.gnt_id, a2.gnt_id, a1.gnt_id, a0.gnt_id};
  assign av = {a4.gnt_valid, a3.gnt_valid, a2.gnt_valid, a1.gnt_valid, a0.gnt_valid};

  typedef struct packed {
    logic [4:0][3:0] g;
    logic [4:0][1:0] id;
    logic [4:0]      v;
  } exp_t;
  exp_t q[$];

  int pn[5] = '{4, 4, 4, 4, 1};
  int pm[5] = '{1, 1, 0, 0, 1};
  int ph[5] = '{1, 0, 0, 1, 1};
  int cur[5] = '{-1, -1, -1, -1, -1};
  int ptr[5] = '{0, 0, 0, 0, 0};
  int tests = 0;
  int fails = 0;

  // Reference: a grant is an index (or -1 for none); round robin scans from ptr with wrap
  task automatic drive(input logic rs, input logic [3:0] rq);
    exp_t e;
    logic [3:0] m;
    @(negedge clk);
    rst = rs;
    req = rq;
    for (int d = 0; d < 5; d++) begin
      m = (pn[d] == 1) ? (rq & 4'b0001) : rq;
      if (rs) begin
        cur[d] = -1;
        ptr[d] = 0;
      end else if (ph[d] == 1 && cur[d] >= 0 && m[cur[d]]) begin
      end else if (m == 0) begin
        cur[d] = -1;
      end else begin
        for (int j = pn[d] - 1; j >= 0; j--) begin
          int k;
          k = (pm[d] == 1) ? (ptr[d] + j) % pn[d] : j;
          if (m[k]) cur[d] = k;
        end
        if (pm[d] == 1) ptr[d] = (cur[d] + 1) % pn[d];
      end
      e.g[d]  = (cur[d] < 0) ? 4'b0 : 4'(1 << cur[d]);
      e.id[d] = (cur[d] < 0) ? 2'd0 : 2'(cur[d]);
      e.v[d]  = (cur[d] >= 0);
    end
    q.push_back(e);
  endtask

  task automatic rep(input logic rs, input logic [3:0] rq, input int n);
    for (int i = 0; i < n; i++) drive(rs, rq);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int d = 0; d < 5; d++) begin
          tests++;
          if (ag[d] !== e.g[d] || av[d] !== e.v[d] || ai[d] !== e.id[d]) begin
            fails++;
            $display("FAIL grant dut%0d t=%0t req=%b got gnt=%b valid=%b id=%0d want gnt=%b valid=%b id=%0d",
                     d, $time, req, ag[d], av[d], ai[d], e.g[d], e.v[d], e.id[d]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b0;
    rep(1, 4'b1111, 2);
    rep(0, 4'b1111, 5);
    rep(0, 4'b0011, 3);
    rep(0, 4'b0010, 2);
    rep(0, 4'b1010, 2);
    rep(0, 4'b1001, 3);
    rep(0, 4'b0100, 2);
    rep(0, 4'b0000, 3);
    rep(0, 4'b1111, 2);
    rep(0, 4'b0100, 2);
    rep(1, 4'b0100, 1);
    rep(0, 4'b1111, 2);
    for (int i = 0; i < 600; i++) drive($urandom_range(99) < 2, 4'($urandom));
    rep(0, 4'b0000, 2);
    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
